// File: rtl/mb_pkg.sv
// -----------------------------------------------------------------------------
// mb_pkg
// Shared definitions for the MainBand transmit flit packer:
//   FLIT_BYTES / BEAT_BYTES / BEATS_PER_FLIT  flit geometry
//   CRC16_POLY / CRC16_INIT                   CRC-16-CCITT constants
//   flit_t                                    64-entry byte array (index = byte)
//   pack_state_e                              packer FSM states
//   crc16_step()                              one-byte MSB-first CRC-16 update
// -----------------------------------------------------------------------------
package mb_pkg;

  localparam int FLIT_BYTES     = 64;
  localparam int BEAT_BYTES     = 2;
  localparam int BEATS_PER_FLIT = FLIT_BYTES / BEAT_BYTES;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef logic [7:0] flit_t [FLIT_BYTES];

  // FILL accepts beats, FOLD finishes the CRC over pad bytes (CRC build only),
  // HOLD waits for the issue window.
  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_FOLD = 2'd1,
    ST_HOLD = 2'd2
  } pack_state_e;

  // CRC-16-CCITT, no reflection: the byte enters at the top of the register.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                             input logic [7:0]  data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/mb_crc16_byte.sv
// -----------------------------------------------------------------------------
// mb_crc16_byte
// Combinational single-byte CRC-16-CCITT step. Only built when
// MB_TX_PACKER_CRC_EN is defined; the default build has no CRC logic at all.
//   crc_i   running CRC before this byte
//   data_i  byte to fold in
//   crc_o   running CRC after this byte
// -----------------------------------------------------------------------------
`ifdef MB_TX_PACKER_CRC_EN
module mb_crc16_byte
  import mb_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  assign crc_o = crc16_step(crc_i, data_i);

endmodule
`endif

// File: rtl/mb_tx_flit_packer.sv
// -----------------------------------------------------------------------------
// mb_tx_flit_packer
// Packs a 16-bit beat stream into 64-byte flits and issues each flit to the
// MainBand transmitter with a one-cycle valid pulse. The accumulation buffer
// fills while the previously issued flit stays stable on flit_o. Issue is
// metered by a minimum gap and held off while the transmitter reports busy.
//
// Ports:
//   clk_100MHz    clock
//   reset         asynchronous, active-high
//   in_data_i     beat payload, [7:0] -> even byte, [15:8] -> odd byte
//   in_valid_i    beat valid
//   in_last_i     final beat of a packet; closes the flit early
//   in_ready_o    packer can accept a beat this cycle
//   flit_o        64-byte flit held for the transmitter
//   flit_valid_o  one-cycle issue pulse
//   tx_busy_i     transmitter busy, asynchronous to clk_100MHz
//   pending_o     a closed flit is waiting to be issued
//   flit_cnt_o    issued-flit counter, wraps modulo 2^16
//
// Build option MB_TX_PACKER_CRC_EN: payload shrinks to 31 beats and bytes
// 62..63 carry CRC-16-CCITT over bytes 0..61; one extra cycle after close
// folds the pad bytes into the CRC.
// -----------------------------------------------------------------------------
module mb_tx_flit_packer
  import mb_pkg::*;
#(
  parameter int unsigned MIN_GAP  = 4,      // 2..15
  parameter logic [7:0]  PAD_BYTE = 8'h00
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic [15:0] in_data_i,
  input  logic        in_valid_i,
  input  logic        in_last_i,
  output logic        in_ready_o,
  output logic [7:0]  flit_o [FLIT_BYTES],
  output logic        flit_valid_o,
  input  logic        tx_busy_i,
  output logic        pending_o,
  output logic [15:0] flit_cnt_o
);

`ifdef MB_TX_PACKER_CRC_EN
  localparam int PAYLOAD_BEATS = BEATS_PER_FLIT - 1;
`else
  localparam int PAYLOAD_BEATS = BEATS_PER_FLIT;
`endif
  localparam logic [4:0] LAST_IDX = 5'(PAYLOAD_BEATS - 1);
  localparam logic [3:0] GAP_LOAD = 4'(MIN_GAP - 1);

  pack_state_e state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [3:0]  gap_q, gap_d;
  logic        busy_meta_q, busy_meta_d;
  logic        busy_s_q, busy_s_d;
  logic [15:0] cnt_q, cnt_d;
  logic        flit_valid_q, flit_valid_d;
  flit_t       acc_q, acc_d;
  flit_t       flit_q, flit_d;

  logic        accept;
  logic        issue;
  logic        close;
  logic [5:0]  lo_byte;

`ifdef MB_TX_PACKER_CRC_EN
  logic [15:0] crc_q, crc_d;
  logic [4:0]  fill_beats_q, fill_beats_d;
  logic [15:0] crc_mid, crc_beat, crc_fold;

  // Low byte first, then high byte, matching byte order in the flit.
  mb_crc16_byte u_crc_lo (
    .crc_i  (crc_q),
    .data_i (in_data_i[7:0]),
    .crc_o  (crc_mid)
  );

  mb_crc16_byte u_crc_hi (
    .crc_i  (crc_mid),
    .data_i (in_data_i[15:8]),
    .crc_o  (crc_beat)
  );

  // Bytes from the first unwritten one up to 61 are pad; fold them in one go.
  always_comb begin
    crc_fold = crc_q;
    for (int b = 0; b < FLIT_BYTES - 2; b++) begin
      if (6'(b) >= {fill_beats_q, 1'b0}) begin
        crc_fold = crc16_step(crc_fold, PAD_BYTE);
      end
    end
  end
`endif

  assign in_ready_o   = (state_q == ST_FILL);
  assign pending_o    = (state_q != ST_FILL);
  assign accept       = in_valid_i && in_ready_o;
  assign close        = accept && ((idx_q == LAST_IDX) || in_last_i);
  assign issue        = (state_q == ST_HOLD) && (gap_q == 4'd0) && !busy_s_q;
  assign lo_byte      = {idx_q, 1'b0};

  assign flit_o       = flit_q;
  assign flit_valid_o = flit_valid_q;
  assign flit_cnt_o   = cnt_q;

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    state_d      = state_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    flit_d       = flit_q;
    flit_valid_d = 1'b0;
    cnt_d        = cnt_q;
    gap_d        = (gap_q != 4'd0) ? gap_q - 4'd1 : 4'd0;
    busy_meta_d  = tx_busy_i;
    busy_s_d     = busy_meta_q;
`ifdef MB_TX_PACKER_CRC_EN
    crc_d        = crc_q;
    fill_beats_d = fill_beats_q;
`endif

    case (state_q)
      ST_FILL: begin
        if (accept) begin
          acc_d[lo_byte]        = in_data_i[7:0];
          acc_d[lo_byte + 6'd1] = in_data_i[15:8];
`ifdef MB_TX_PACKER_CRC_EN
          crc_d = crc_beat;
`endif
          if (close) begin
            idx_d = 5'd0;
`ifdef MB_TX_PACKER_CRC_EN
            fill_beats_d = idx_q + 5'd1;
            state_d      = ST_FOLD;
`else
            state_d      = ST_HOLD;
`endif
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end

`ifdef MB_TX_PACKER_CRC_EN
      ST_FOLD: begin
        acc_d[FLIT_BYTES-2] = crc_fold[15:8];
        acc_d[FLIT_BYTES-1] = crc_fold[7:0];
        crc_d               = CRC16_INIT;
        state_d             = ST_HOLD;
      end
`endif

      ST_HOLD: begin
        if (issue) begin
          flit_d       = acc_q;
          flit_valid_d = 1'b1;
          cnt_d        = cnt_q + 16'd1;
          gap_d        = GAP_LOAD;
          for (int k = 0; k < FLIT_BYTES; k++) begin
            acc_d[k] = PAD_BYTE;
          end
          state_d = ST_FILL;
        end
      end

      default: state_d = ST_FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the
  // combinational block above uses blocking ones so later lines see earlier.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q      <= ST_FILL;
      idx_q        <= 5'd0;
      gap_q        <= 4'd0;
      busy_meta_q  <= 1'b0;
      busy_s_q     <= 1'b0;
      cnt_q        <= 16'd0;
      flit_valid_q <= 1'b0;
      // NOTE: both byte arrays are reset on purpose: a discarded partial flit
      // must not leak stale bytes, and early-closed flits rely on pad content.
      for (int k = 0; k < FLIT_BYTES; k++) begin
        acc_q[k]  <= PAD_BYTE;
        flit_q[k] <= 8'h00;
      end
`ifdef MB_TX_PACKER_CRC_EN
      crc_q        <= CRC16_INIT;
      fill_beats_q <= 5'd0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      busy_meta_q  <= busy_meta_d;
      busy_s_q     <= busy_s_d;
      cnt_q        <= cnt_d;
      flit_valid_q <= flit_valid_d;
      acc_q        <= acc_d;
      flit_q       <= flit_d;
`ifdef MB_TX_PACKER_CRC_EN
      crc_q        <= crc_d;
      fill_beats_q <= fill_beats_d;
`endif
    end
  end

endmodule

// File: tb/tb_mb_tx_flit_packer.sv
// -----------------------------------------------------------------------------
// tb_mb_tx_flit_packer
// Self-checking bench for mb_tx_flit_packer. Expected flits come from a
// byte-array model of the packing rules; the CRC reference is a bitwise
// polynomial division. Honours MB_TX_PACKER_CRC_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_mb_tx_flit_packer;
  import mb_pkg::*;

  localparam int         MIN_GAP = 4;
  localparam logic [7:0] PAD     = 8'h00;
`ifdef MB_TX_PACKER_CRC_EN
  localparam int PAYLOAD = 31;
  localparam int EXTRA   = 1;
`else
  localparam int PAYLOAD = 32;
  localparam int EXTRA   = 0;
`endif
  localparam int LAT0    = 1 + EXTRA;
  localparam int SPACING = PAYLOAD + 1 + EXTRA;

  typedef logic [511:0] flat_t;

  typedef struct {
    int          nbeats;
    bit          last;
    logic [15:0] base;
    logic [15:0] inc;
    int          busy_rel;   // 0: no busy; else release this many cycles after close
    int          exp_lat;    // cycles from closing edge to flit_valid_o
  } vec_t;

  logic        clk_100MHz = 1'b0;
  logic        reset;
  logic [15:0] in_data_i;
  logic        in_valid_i;
  logic        in_last_i;
  logic        in_ready_o;
  logic [7:0]  flit_o [FLIT_BYTES];
  logic        flit_valid_o;
  logic        tx_busy_i;
  logic        pending_o;
  logic [15:0] flit_cnt_o;

  always #5 clk_100MHz = ~clk_100MHz;

  mb_tx_flit_packer #(
    .MIN_GAP  (MIN_GAP),
    .PAD_BYTE (PAD)
  ) dut (
    .clk_100MHz   (clk_100MHz),
    .reset        (reset),
    .in_data_i    (in_data_i),
    .in_valid_i   (in_valid_i),
    .in_last_i    (in_last_i),
    .in_ready_o   (in_ready_o),
    .flit_o       (flit_o),
    .flit_valid_o (flit_valid_o),
    .tx_busy_i    (tx_busy_i),
    .pending_o    (pending_o),
    .flit_cnt_o   (flit_cnt_o)
  );

  int    tests_run    = 0;
  int    tests_failed = 0;
  flat_t exp_q[$];
  flat_t m_flit;
  int    m_beats;
  int    exp_cnt;
  vec_t  vecs[6];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_100MHz);
    #1;
  endtask

  function automatic flat_t dut_flat();
    flat_t f;
    for (int k = 0; k < FLIT_BYTES; k++) f[8*k +: 8] = flit_o[k];
    return f;
  endfunction

  // Reference CRC: shift the 62-byte message in bit by bit, MSB first.
  function automatic logic [15:0] crc_ref(input flat_t f);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int k = 0; k < 62; k++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ f[8*k + b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  task automatic mdl_reset();
    m_flit  = {64{PAD}};
    m_beats = 0;
  endtask

  task automatic mdl_beat(input logic [15:0] d, input logic last);
    logic [15:0] c;
    m_flit[16*m_beats +: 16] = d;
    m_beats++;
    if (m_beats == PAYLOAD || last) begin
`ifdef MB_TX_PACKER_CRC_EN
      c = crc_ref(m_flit);
      m_flit[8*62 +: 8] = c[15:8];
      m_flit[8*63 +: 8] = c[7:0];
`else
      c = 16'h0;
`endif
      exp_q.push_back(m_flit);
      mdl_reset();
    end
  endtask

  // Called in the cycle flit_valid_o is seen high.
  task automatic on_pulse(input string name);
    flat_t e;
    check({name, "_expected"}, (exp_q.size() > 0), 1'b1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({name, "_flit"}, dut_flat(), e);
    end
    exp_cnt++;
    check({name, "_cnt"}, flit_cnt_o, 16'(exp_cnt));
  endtask

  task automatic run_vec(input vec_t v, input int id);
    string nm;
    int    e;
    bit    got;
    flat_t saved;
    nm = $sformatf("vec%0d", id);
    if (v.busy_rel > 0) begin
      tx_busy_i = 1'b1;
      repeat (3) step();
    end
    for (int b = 0; b < v.nbeats; b++) begin
      in_valid_i = 1'b1;
      in_data_i  = v.base + 16'(b) * v.inc;
      in_last_i  = v.last && (b == v.nbeats - 1);
      check({nm, "_ready_fill"}, in_ready_o, 1'b1);
      mdl_beat(in_data_i, in_last_i);
      step();
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    e   = 0;
    got = 1'b0;
    while (!got && e < 60) begin
      if (v.busy_rel > 0 && e == v.busy_rel) tx_busy_i = 1'b0;
      check({nm, "_hold_rdy_pend"}, {in_ready_o, pending_o}, 2'b01);
      step();
      e++;
      if (flit_valid_o) got = 1'b1;
    end
    tx_busy_i = 1'b0;
    check({nm, "_latency"}, 32'(e), 32'(v.exp_lat));
    if (got) begin
      on_pulse(nm);
      check({nm, "_post_rdy_pend"}, {in_ready_o, pending_o}, 2'b10);
      saved = dut_flat();
      step();
      check({nm, "_pulse_width"}, flit_valid_o, 1'b0);
      check({nm, "_flit_stable"}, dut_flat(), saved);
    end else begin
      exp_q.delete();
    end
    repeat (MIN_GAP + 2) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int    t, prev_t, pulses, next, last_pulse;
    bit    stable, acc, l;
    flat_t snap;
    logic [15:0] d;

    vecs[0] = '{PAYLOAD, 1'b0, 16'h0100, 16'h0001, 0,  LAT0};
    vecs[1] = '{3,       1'b1, 16'h1234, 16'h0101, 0,  LAT0};
    vecs[2] = '{1,       1'b1, 16'hBEEF, 16'h0000, 0,  LAT0};
    vecs[3] = '{PAYLOAD, 1'b1, 16'h7700, 16'h0001, 0,  LAT0};
    vecs[4] = '{5,       1'b1, 16'h4000, 16'h0003, 10, 13};
    vecs[5] = '{PAYLOAD, 1'b0, 16'h0000, 16'h0000, 0,  LAT0};

    reset      = 1'b1;
    in_data_i  = 16'h0;
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    tx_busy_i  = 1'b0;
    exp_cnt    = 0;
    mdl_reset();
    step();
    step();
    check("rst_valid", flit_valid_o, 1'b0);
    check("rst_ready", in_ready_o, 1'b1);
    check("rst_pending", pending_o, 1'b0);
    check("rst_cnt", flit_cnt_o, 16'h0);
    check("rst_flit", dut_flat(), '0);
    reset = 1'b0;
    repeat (2) step();

    // Table-driven vectors
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

`ifdef MB_TX_PACKER_CRC_EN
    check("crc_zero_bytes", {flit_o[62], flit_o[63]}, crc_ref('0));
`endif

    // Streaming: in_valid held high for four full flits
    in_valid_i = 1'b1;
    in_last_i  = 1'b0;
    next   = 0;
    pulses = 0;
    prev_t = 0;
    t      = 0;
    stable = 1'b1;
    snap   = '0;
    while (pulses < 4 && t < 400) begin
      in_data_i = 16'h3000 + 16'(next);
      acc = in_ready_o;
      d   = in_data_i;
      step();
      t++;
      if (acc) begin
        mdl_beat(d, 1'b0);
        next++;
      end
      if (flit_valid_o) begin
        if (pulses > 0) begin
          check($sformatf("stream_spacing%0d", pulses), 32'(t - prev_t), 32'(SPACING));
          check($sformatf("stream_hold%0d", pulses), stable, 1'b1);
        end
        on_pulse($sformatf("stream%0d", pulses));
        snap   = dut_flat();
        stable = 1'b1;
        prev_t = t;
        pulses++;
      end else if (pulses > 0 && dut_flat() !== snap) begin
        stable = 1'b0;
      end
    end
    in_valid_i = 1'b0;
    check("stream_pulses", 32'(pulses), 32'd4);
    exp_q.delete();
    mdl_reset();
    repeat (MIN_GAP + 2) step();

    // Reset after beat 20: partial flit discarded, no pulse
    for (int b = 0; b < 20; b++) begin
      in_valid_i = 1'b1;
      in_data_i  = 16'hEE00 + 16'(b);
      step();
    end
    in_valid_i = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_valid", flit_valid_o, 1'b0);
    check("midrst_ready", in_ready_o, 1'b1);
    check("midrst_pending", pending_o, 1'b0);
    check("midrst_cnt", flit_cnt_o, 16'h0);
    check("midrst_flit", dut_flat(), '0);
    exp_cnt = 0;
    mdl_reset();
    step();
    reset = 1'b0;
    pulses = 0;
    repeat (8) begin
      step();
      if (flit_valid_o) pulses++;
    end
    check("midrst_no_pulse", 32'(pulses), 32'd0);
    begin
      vec_t v;
      v = '{PAYLOAD, 1'b0, 16'hA500, 16'h0001, 0, LAT0};
      run_vec(v, 90);
    end

    // Randomized traffic against the model
    last_pulse = -1;
    t = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if ($urandom_range(0, 19) == 0) tx_busy_i = ~tx_busy_i;
      in_valid_i = ($urandom_range(0, 9) < 7);
      in_data_i  = 16'($urandom);
      in_last_i  = ($urandom_range(0, 15) == 0);
      acc = in_valid_i && in_ready_o;
      d   = in_data_i;
      l   = in_last_i;
      step();
      t++;
      if (acc) mdl_beat(d, l);
      if (flit_valid_o) begin
        if (last_pulse >= 0) check("rnd_gap", ((t - last_pulse) >= MIN_GAP), 1'b1);
        on_pulse("rnd");
        last_pulse = t;
      end
    end
    tx_busy_i  = 1'b0;
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    repeat (50) begin
      step();
      t++;
      if (flit_valid_o) begin
        if (last_pulse >= 0) check("rnd_gap", ((t - last_pulse) >= MIN_GAP), 1'b1);
        on_pulse("rnd");
        last_pulse = t;
      end
    end
    check("rnd_drained", 32'(exp_q.size()), 32'd0);
    check("rnd_final_cnt", flit_cnt_o, 16'(exp_cnt));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mb_tx_flit_packer.md
Name: mb_tx_flit_packer

Overview:
Upstream feeder for the MainBand transmitter, clocked on clk_100MHz. It packs a 16-bit beat stream from the adapter into 64-byte flits and issues each flit with a one-cycle valid pulse. It meters issue rate so the transmitter's flit buffer is never overrun. It double-buffers so the next flit fills while the issued one is held stable on the output.

Parameters:
BEATS_PER_FLIT, 32, 16-bit beats per 64-byte flit; fixed, not user-tunable
MIN_GAP, 4, minimum clk_100MHz cycles between consecutive flit_valid_o pulses (range 2..15)
PAD_BYTE, 8'h00, fill value for bytes not written when a flit is closed early by in_last_i

Ports:
clk_100MHz  in  1  slow clock
reset  in  1  asynchronous, active-high
in_data_i  in  16  beat payload; [7:0] is the lower byte index, [15:8] the upper
in_valid_i  in  1  beat valid
in_last_i  in  1  qualifies the beat as the final beat of a packet; closes the flit early
in_ready_o  out  1  packer can accept a beat this cycle
flit_o  out  8 x [63:0]  unpacked byte array; drives the transmitter's data input
flit_valid_o  out  1  one-cycle issue pulse; drives the transmitter's valid input
tx_busy_i  in  1  transmitter's transmitting flag, asynchronous to clk_100MHz
pending_o  out  1  a complete flit is waiting in the accumulation buffer
flit_cnt_o  out  16  issued-flit counter; wraps modulo 2^16

Behaviour:
- Reset (async assert, sync release): flit_o all bytes 0, flit_valid_o 0, in_ready_o 1, pending_o 0, flit_cnt_o 0. Beat index 0, gap counter 0, synchroniser flops 0, accumulation buffer filled with PAD_BYTE.
- Beat acceptance:
  - A beat is accepted when in_valid_i && in_ready_o.
  - An accepted beat writes acc[2*idx] <= in_data_i[7:0] and acc[2*idx+1] <= in_data_i[15:8].
  - in_ready_o = !pending (combinational from state).
- Flit close: the flit closes on acceptance at idx==BEATS_PER_FLIT-1, or on any accepted beat with in_last_i=1. At close: pending <= 1 and idx <= 0. Bytes after the last written beat keep PAD_BYTE.
- tx_busy_i is synchronised by a 2-flop synchroniser into busy_s.
- Gap counter: loaded with MIN_GAP-1 on issue, then decrements to 0 and saturates there.
- Issue condition: pending && gap==0 && !busy_s. On the issue cycle:
  - flit_o <= acc, flit_valid_o <= 1 for exactly one cycle.
  - pending <= 0, flit_cnt_o <= flit_cnt_o+1.
  - acc is refilled with PAD_BYTE on the same edge.
- Latency: the earliest flit_valid_o is the cycle after the closing beat is accepted, given gap==0 and busy_s==0. flit_o is stable from that edge until the next issue, so it holds for at least MIN_GAP cycles.
- States:
  - FILL (pending=0): accept beats.
  - HOLD (pending=1): in_ready_o=0, wait for the issue condition.
  - Transitions: FILL->HOLD at close; HOLD->FILL at issue.
- Simultaneous events: no beat is accepted in the issue cycle because in_ready_o=0 in HOLD. The next beat can be accepted the cycle after issue. Back-to-back full flits therefore sustain 1 flit per max(BEATS_PER_FLIT+1, MIN_GAP) cycles.
- in_last_i on beat 31 is identical to a normal full close.
- in_valid_i with in_ready_o=0: the beat is ignored and the source must hold it. Changing in_data_i while stalled has no effect.
- Reset mid-fill or mid-HOLD: partial or pending flit discarded, no flit_valid_o pulse produced.
- busy_s stuck high: the packer stays in HOLD indefinitely. No timeout.

Optional Feature:
MB_TX_PACKER_CRC_EN
- Defined:
  - Payload capacity is 31 beats; the flit closes at idx==30 or on in_last_i.
  - Bytes 62..63 are replaced at close by CRC-16-CCITT (poly 0x1021, init 0xFFFF, no reflection, no final XOR) over bytes 0..61, pad bytes included.
  - Byte 62 = CRC[15:8], byte 63 = CRC[7:0].
  - The CRC is updated incrementally per accepted beat: low byte first, then high byte. Pad bytes are folded in at close.
  - One extra HOLD cycle is allowed for the pad fold, so issue latency is +1 cycle.
- Undefined: 32 payload beats, no CRC logic, bytes 62..63 carry data.

Decomposition:
- Package mb_pkg holds: FLIT_BYTES=64, BEAT_BYTES=2, CRC16_POLY=16'h1021, CRC16_INIT=16'hFFFF, and typedef flit_t (logic [7:0] [63:0]).
- One sub-module, mb_crc16_byte: combinational single-byte CRC-16 step, instantiated twice per beat under the macro.
- The 2-flop synchroniser is inline.

Test Plan:
- Reset, then 32 beats 16'h0100+i with no gaps -> one flit_valid_o pulse 1 cycle after beat 31; flit_o[2i]=i, flit_o[2i+1]=8'h01; flit_cnt_o=1.
- 3 beats, the third with in_last_i=1 -> issue with bytes 0..5 written and bytes 6..63 equal to PAD_BYTE (8'h00); in_ready_o low only during HOLD.
- 4 full flits streamed with in_valid_i held high, MIN_GAP=4 -> pulses spaced 33 cycles apart; flit_o unchanged between pulses.
- tx_busy_i held high before the flit closes, released 10 cycles later -> pulse 3 cycles after release (2 sync stages + 1); in_ready_o stays 0 throughout.
- Reset asserted after beat 20 -> no pulse, all outputs at reset values; the next 32 beats produce a clean flit with no stale bytes.
- MB_TX_PACKER_CRC_EN with 31 beats of 16'h0000 -> bytes 62..63 equal the reference-model CRC of 62 zero bytes; issue on the second cycle after beat 30.
